// File: rtl/color_det_pkg.sv
// Shared types for the dice colour detector.
// Colour codes, FSM states and default counter width.
package color_det_pkg;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    RED   = 2'd1,
    GREEN = 2'd2,
    BLUE  = 2'd3
  } color_e;

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    ACCUM  = 2'd1,
    DECIDE = 2'd2,
    FILTER = 2'd3
  } state_e;

  localparam int CNT_W_DEF = 17;

endpackage

// File: rtl/rgb565_classifier.sv
// Combinational RGB565 pixel classifier.
// A pixel is a colour when that channel is strong and the other two are weak.
module rgb565_classifier
  import color_det_pkg::*;
#(
  parameter logic [4:0] CH_HI = 5'd20,
  parameter logic [4:0] CH_LO = 5'd12
) (
  input  logic [15:0] i_rgb565,
  output color_e      o_color
);

  logic [4:0] w_r, w_g, w_b;
  logic       w_rs, w_gs, w_bs;
  logic       w_rw, w_gw, w_bw;

  assign w_r = i_rgb565[15:11];
  assign w_g = i_rgb565[10:6];
  assign w_b = i_rgb565[4:0];

  assign w_rs = w_r >= CH_HI;
  assign w_gs = w_g >= CH_HI;
  assign w_bs = w_b >= CH_HI;
  assign w_rw = w_r < CH_LO;
  assign w_gw = w_g < CH_LO;
  assign w_bw = w_b < CH_LO;

  always_comb begin
    o_color = NONE;
    unique case (1'b1)
      (w_rs && w_gw && w_bw): o_color = RED;
      (w_gs && w_rw && w_bw): o_color = GREEN;
      (w_bs && w_rw && w_gw): o_color = BLUE;
      default:                o_color = NONE;
    endcase
  end

endmodule

// File: rtl/dice_color_detector.sv
// Per-frame dominant colour detector over a raster window,
// with a frame-to-frame debounce producing a stable colour.
module dice_color_detector
  import color_det_pkg::*;
#(
  parameter logic [9:0] WIN_X0        = 10'd0,
  parameter logic [9:0] WIN_X1        = 10'd319,
  parameter logic [9:0] WIN_Y0        = 10'd240,
  parameter logic [9:0] WIN_Y1        = 10'd479,
  parameter logic [4:0] CH_HI         = 5'd20,
  parameter logic [4:0] CH_LO         = 5'd12,
  parameter int         MIN_PIXELS    = 2000,
  parameter int         STABLE_FRAMES = 3,
  parameter int         CNT_W         = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             DE,
  input  logic [9:0]       x_pixel,
  input  logic [9:0]       y_pixel,
  input  logic [15:0]      rgb565,
  output color_e           frame_color,
  output logic             frame_valid,
  output color_e           stable_color,
  output logic             color_change,
  output logic [CNT_W-1:0] red_cnt,
  output logic [CNT_W-1:0] green_cnt,
  output logic [CNT_W-1:0] blue_cnt
);

  localparam int RUN_W = $clog2(STABLE_FRAMES + 1);
  localparam logic [RUN_W-1:0] L_STABLE = RUN_W'(STABLE_FRAMES);
  localparam logic [CNT_W-1:0] L_MIN = CNT_W'(MIN_PIXELS);
  localparam logic [9:0] L_XSPAN = WIN_X1 - WIN_X0;
  localparam logic [9:0] L_YSPAN = WIN_Y1 - WIN_Y0;

  logic [9:0]       r_dx, r_dy;
  logic             r_dde;
  state_e           r_state, w_state_nx;
  logic [CNT_W-1:0] r_cnt_r, r_cnt_g, r_cnt_b;
  logic [RUN_W-1:0] r_run, w_run_nx;
  color_e           r_prev;

  color_e           w_cls, w_best, w_decided;
  logic [CNT_W-1:0] w_best_cnt;
  logic [9:0]       w_xo, w_yo;
  logic             w_in_win, w_last, w_start, w_update;

  rgb565_classifier #(
    .CH_HI(CH_HI),
    .CH_LO(CH_LO)
  ) u_cls (
    .i_rgb565(rgb565),
    .o_color (w_cls)
  );

  // Offset-compare keeps the window test valid when a bound is zero.
  assign w_xo     = r_dx - WIN_X0;
  assign w_yo     = r_dy - WIN_Y0;
  assign w_in_win = r_dde && (w_xo <= L_XSPAN) && (w_yo <= L_YSPAN);
  assign w_last   = w_in_win && (r_dx == WIN_X1) && (r_dy == WIN_Y1);
  assign w_start  = r_dde && (r_dx == 10'd0) && (r_dy == 10'd0);

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      SYNC:    if (w_start) w_state_nx = ACCUM;
      ACCUM:   if (w_last) w_state_nx = DECIDE;
      DECIDE:  w_state_nx = FILTER;
      FILTER:  w_state_nx = ACCUM;
      default: w_state_nx = SYNC;
    endcase
  end

  always_comb begin
    w_best     = RED;
    w_best_cnt = r_cnt_r;
    if (r_cnt_g > w_best_cnt) begin
      w_best     = GREEN;
      w_best_cnt = r_cnt_g;
    end
    if (r_cnt_b > w_best_cnt) begin
      w_best     = BLUE;
      w_best_cnt = r_cnt_b;
    end
    w_decided = (w_best_cnt >= L_MIN) ? w_best : NONE;
  end

  always_comb begin
    w_run_nx = RUN_W'(1);
    if (frame_color == NONE)
      w_run_nx = '0;
    else if (frame_color == r_prev)
      w_run_nx = (r_run >= L_STABLE) ? L_STABLE : r_run + RUN_W'(1);
    w_update = (w_run_nx == L_STABLE) &&
               (frame_color != stable_color) &&
               (frame_color != NONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= SYNC;
    else       r_state <= w_state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dx         <= '0;
      r_dy         <= '0;
      r_dde        <= 1'b0;
      r_cnt_r      <= '0;
      r_cnt_g      <= '0;
      r_cnt_b      <= '0;
      r_run        <= '0;
      r_prev       <= NONE;
      frame_color  <= NONE;
      frame_valid  <= 1'b0;
      stable_color <= NONE;
      color_change <= 1'b0;
      red_cnt      <= '0;
      green_cnt    <= '0;
      blue_cnt     <= '0;
    end else begin
      r_dx         <= x_pixel;
      r_dy         <= y_pixel;
      r_dde        <= DE;
      frame_valid  <= (r_state == DECIDE);
      color_change <= (r_state == FILTER) && w_update;
      if (r_state == ACCUM && w_in_win) begin
        if (w_cls == RED)   r_cnt_r <= r_cnt_r + CNT_W'(1);
        if (w_cls == GREEN) r_cnt_g <= r_cnt_g + CNT_W'(1);
        if (w_cls == BLUE)  r_cnt_b <= r_cnt_b + CNT_W'(1);
      end
      if (r_state == DECIDE) begin
        red_cnt     <= r_cnt_r;
        green_cnt   <= r_cnt_g;
        blue_cnt    <= r_cnt_b;
        frame_color <= w_decided;
        r_cnt_r     <= '0;
        r_cnt_g     <= '0;
        r_cnt_b     <= '0;
      end
      if (r_state == FILTER) begin
        r_run  <= w_run_nx;
        r_prev <= frame_color;
        if (w_update) stable_color <= frame_color;
      end
    end
  end

endmodule

// File: doc/dice_color_detector.md
Name: dice_color_detector

Overview:
- Consumes the dice-camera RGB565 stream (frame-buffer read data) with the VGA raster position and DE, all in the 25 MHz pixel-clock domain.
- Classifies every pixel inside the dice window as RED, GREEN, BLUE or none, and counts each class per frame.
- At window end, decides the dominant frame colour, then debounces it across consecutive frames.
- Provides a stable colour plus a change pulse to Display_Overlay and UI_Generator.

Parameters:
WIN_X0, 0, first window column (inclusive)
WIN_X1, 319, last window column (inclusive)
WIN_Y0, 240, first window row (inclusive)
WIN_Y1, 479, last window row (inclusive)
CH_HI, 20, 5-bit channel level at or above which a channel is "strong"
CH_LO, 12, 5-bit channel level below which a channel is "weak"
MIN_PIXELS, 2000, minimum winning count; below this the frame colour is NONE
STABLE_FRAMES, 3, consecutive identical non-NONE frame colours required to update stable_color
CNT_W, 17, counter width; must hold (WIN_X1-WIN_X0+1)*(WIN_Y1-WIN_Y0+1)

Ports:
clk  in  1  pixel clock (25 MHz)
reset  in  1  asynchronous, active-high reset
DE  in  1  display enable for x_pixel/y_pixel
x_pixel  in  10  raster column
y_pixel  in  10  raster row
rgb565  in  16  pixel data; belongs to the x/y/DE presented one cycle earlier (1-cycle buffer read latency)
frame_color  out  2  decided colour of the last frame (color_e)
frame_valid  out  1  one-cycle pulse when frame_color updates
stable_color  out  2  debounced colour (color_e)
color_change  out  1  one-cycle pulse when stable_color changes
red_cnt, green_cnt, blue_cnt  out  CNT_W each  latched per-frame counts

Behaviour:
- Reset (asynchronous assert): all outputs 0 (NONE); counters, run counter and delay registers cleared; FSM in SYNC.
- Alignment: x_pixel, y_pixel and DE are registered once (dX, dY, dDE). Each cycle, rgb565 is paired with dX/dY/dDE.
- in_win = dDE && WIN_X0<=dX<=WIN_X1 && WIN_Y0<=dY<=WIN_Y1.
- Classification uses R=rgb565[15:11], G=rgb565[10:6] (G6 MSBs), B=rgb565[4:0]:
  - RED: R>=CH_HI && G<CH_LO && B<CH_LO.
  - GREEN and BLUE: same rule with the strong channel swapped.
  - At most one class per pixel; otherwise the pixel is not counted.
- FSM states:
  - SYNC: wait for the aligned frame start (dDE && dX==0 && dY==0), then enter ACCUM. A partial frame after reset is never counted.
  - ACCUM: the matching counter increments at each clock edge where in_win holds and the pixel is classified. On the edge that processes aligned (WIN_X1,WIN_Y1) with in_win, the final increment is applied and the FSM enters DECIDE.
  - DECIDE (one cycle):
    - Latch counts into red/green/blue_cnt.
    - max = largest count, tie priority RED>GREEN>BLUE.
    - frame_color = max>=MIN_PIXELS ? its colour : NONE.
    - frame_valid high for exactly the next cycle.
    - Clear the counters; go to FILTER.
  - FILTER (one cycle):
    - If frame_color==NONE: run=0.
    - Else if frame_color==prev_color: run=min(run+1, STABLE_FRAMES).
    - Else: run=1.
    - prev_color<=frame_color.
    - If run reaches STABLE_FRAMES and frame_color!=stable_color (non-NONE): update stable_color and pulse color_change for one cycle.
    - Then go to ACCUM; the next window is reached at least one line later, so no pixel is lost.
- Latency: frame_valid rises 1 cycle after the last window pixel edge; color_change rises 2 cycles after it.
- Counters never overflow given CNT_W. The window is entirely in the active area; DE low inside the window rows means the pixel is not counted.
- Reset mid-frame: immediate clear; the resumed frame is discarded until the next (0,0).
- stable_color never returns to NONE except via reset.

Decomposition:
- Package color_det_pkg:
  - color_e enum (NONE=0, RED=1, GREEN=2, BLUE=3, 2 bits)
  - FSM state enum (SYNC, ACCUM, DECIDE, FILTER)
  - default CNT_W constant
- Sub-module rgb565_classifier: combinational; inputs rgb565, CH_HI, CH_LO parameters; output color_e. Unit-testable on its own.

Test Plan:
1. Full VGA raster, window filled with 16'hF800 for 1 frame after sync → frame_valid pulse; red_cnt=76800, green/blue=0; frame_color=RED; stable_color stays NONE.
2. Same red frame ×3 → color_change pulse on frame 3, exactly 2 cycles after the (319,479) pixel edge; stable_color=RED.
3. Window half 16'h07E0, half 16'h001F (38400 each) → tie → frame_color=GREEN.
4. Window 16'hFFFF (white) → all counts 0 → frame_color=NONE; run resets; 2 RED, 1 NONE, 2 RED sequence → no color_change.
5. Only 1999 red pixels, rest black → frame_color=NONE. With 2000 red pixels → RED.
6. Assert reset at row 300 mid-frame → outputs 0 immediately; the remainder of that frame is ignored; the next full frame produces a correct frame_valid.
